mult_div_seq: RTL
=================

Name: mult_div_seq

Overview:
- Iterative signed multiply/divide sequencer for the multicycle CPU.
- The main control FSM launches MULT or DIV with a one-cycle start and stalls in a wait state until done.
- The block owns the HI/LO result registers, which the data-source mux reads for MFHI/MFLO.
- Divide-by-zero is flagged to the control FSM, which raises the exception.

Parameters:
- WIDTH, 32, operand width; iteration count = WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  launch pulse from control FSM; sampled only in IDLE.
- op  in  1  0 = MULT, 1 = DIV; sampled with start.
- flush  in  1  synchronous abort (exception/pipeline cancel).
- a  in  WIDTH  multiplicand / dividend (register A value); sampled with start.
- b  in  WIDTH  multiplier / divisor (register B value); sampled with start.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  high with done when DIV had b == 0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset = 0, async):
  - state = IDLE.
  - hi = lo = 0; busy = done = div_zero = 0.
  - Internal counter and work registers cleared.
- Reset mid-operation: aborts immediately; no HI/LO write.
- States: IDLE, CALC, SIGN, DONE.
- IDLE, start = 1, flush = 0:
  - Latch |a|, |b| as WIDTH-bit unsigned magnitudes; |0x80000000| = 0x80000000.
  - Latch sign flags: sa, sb, op.
  - Counter = 0.
  - If op = 1 and b == 0, go to DONE with div_zero set.
  - Otherwise go to CALC.
- CALC, one iteration per cycle, exactly WIDTH cycles; counter increments and CALC -> SIGN when counter == WIDTH-1.
  - MULT: shift-add on a 2*WIDTH-bit unsigned accumulator.
  - DIV: restoring division; shift remainder/quotient left one bit, trial subtract |b|, keep if non-negative, set quotient bit.
- SIGN (1 cycle): write HI/LO, go to DONE.
  - MULT: {hi, lo} = product, negated if sa ^ sb (two's complement, 64-bit).
  - DIV: lo = quotient, negated if sa ^ sb; hi = remainder, negated if sa (truncation toward zero; remainder takes the dividend's sign).
- DONE (1 cycle): done = 1, div_zero as latched, then return to IDLE.
  - HI/LO are already valid while done = 1.
- Latency:
  - Start edge E0; done high in the cycle after edge E0 + WIDTH + 1, i.e. 34 cycles for WIDTH = 32.
  - Divide-by-zero: done and div_zero high in the cycle right after E0.
  - HI/LO are unchanged on divide-by-zero.
- start while busy: ignored; no queueing, no effect on the running operation.
- flush:
  - Any state other than IDLE: return to IDLE on the next edge; no HI/LO write, done stays 0.
  - flush beats start in IDLE; start is dropped.
- HI/LO hold their value between operations; only SIGN writes them.
- Boundary results:
  - 0x80000000 * 0x80000000 -> hi = 0x40000000, lo = 0.
  - 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0 (defined wrap, no overflow flag).
  - 0 / x -> hi = lo = 0.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset check: hold reset = 0, then release -> hi = lo = 0, busy = done = 0. Pulse start with op = 0, a = 7, b = -3 -> busy the following cycle; done exactly 34 cycles after the start edge; {hi, lo} = 0xFFFFFFFF_FFFFFFEB.
- DIV, a = -7, b = 2 -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1), div_zero = 0, done at cycle 34. Repeat with a = 0x80000000, b = -1 -> lo = 0x80000000, hi = 0.
- Divide-by-zero: preload hi = 5, lo = 9 via a MULT; then DIV with b = 0 -> done and div_zero high the cycle after start; hi = 5, lo = 9 unchanged; busy low after one cycle.
- Ignored start: pulse start again at cycles 5 and 20 of a MULT of 0x80000000 * 0x80000000 -> single done at cycle 34; hi = 0x40000000, lo = 0; no second done.
- Flush: assert flush at cycle 10 of a DIV -> IDLE next cycle, no done, HI/LO keep prior values. Assert start and flush together in IDLE -> nothing starts.
- Async reset: drop reset to 0 at cycle 15 of a MULT, between clock edges -> busy, hi and lo go to 0 immediately. After release, a fresh MULT 3 * 4 -> lo = 12, hi = 0 at cycle 34.

Source files
------------

// File: rtl/mult_div_seq.sv
// Iterative signed multiply/divide unit owning the HI/LO registers.
// One shift-add or restoring-divide step per cycle, followed by a sign-fixup cycle.
module mult_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t state, state_next;

  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] work;
  logic [WIDTH-1:0]   operand;
  logic               sa, sb, op_r, dz_r;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               launch, b_zero;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   quo_signed, rem_signed;

  // work holds {acc_hi, multiplier} for MULT and {remainder, dividend/quotient} for DIV
  always_comb begin
    mag_a       = a[WIDTH-1] ? -a : a;
    mag_b       = b[WIDTH-1] ? -b : b;
    b_zero      = (b == '0);
    launch      = start && !flush;
    mul_sum     = {1'b0, work[2*WIDTH-1:WIDTH]} + {1'b0, (work[0] ? operand : {WIDTH{1'b0}})};
    div_shift   = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
    div_diff    = div_shift - {1'b0, operand};
    prod_signed = (sa ^ sb) ? -work : work;
    quo_signed  = (sa ^ sb) ? -work[WIDTH-1:0] : work[WIDTH-1:0];
    rem_signed  = sa ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (launch) state_next = (op && b_zero) ? DONE : CALC;
      CALC: begin
        if (flush)              state_next = IDLE;
        else if (count == LAST) state_next = SIGN;
      end
      SIGN:    state_next = flush ? IDLE : DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      work    <= '0;
      operand <= '0;
      sa      <= 1'b0;
      sb      <= 1'b0;
      op_r    <= 1'b0;
      dz_r    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            operand <= op ? mag_b : mag_a;
            work    <= {{WIDTH{1'b0}}, (op ? mag_a : mag_b)};
            sa      <= a[WIDTH-1];
            sb      <= b[WIDTH-1];
            op_r    <= op;
            dz_r    <= op && b_zero;
            count   <= '0;
          end
        end
        CALC: begin
          count <= count + CW'(1);
          if (op_r) begin
            // Negative trial difference means the subtraction is discarded
            if (div_diff[WIDTH])
              work <= {div_shift[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
            else
              work <= {div_diff[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
          end else begin
            work <= {mul_sum, work[WIDTH-1:1]};
          end
        end
        SIGN: begin
          if (!flush) begin
            if (op_r) begin
              lo <= quo_signed;
              hi <= rem_signed;
            end else begin
              {hi, lo} <= prod_signed;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign div_zero = (state == DONE) && dz_r;

endmodule
